// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/ack data-memory bus between the LSU and memory.
// master drives the request side, slave returns ack and read data.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle B/H/W load/store over a req/ack memory bus.
// Define LSU_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without ack.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  load_store_unit_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        access, misal, start, abort;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        st_q;
  logic [31:0] rdata_q;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  logic [31:0] ext;

  assign access = memread | memwrite;

  always_comb begin
    misal = 1'b0;
    case (funct3[1:0])
      2'b01:   misal = address[0];
      2'b10:   misal = |address[1:0];
      default: misal = 1'b0;
    endcase
  end

  // gated by rst so stall/misalign read 0 while reset is held
  assign start    = rst & (state == IDLE) & access & ~misal;
  assign misalign = rst & (state == IDLE) & access & misal;
  assign stall    = start | (state == BUSY);

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = writedata;
    case (funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << address[1:0];
        wdata_nxt = {4{writedata[7:0]}};
      end
      2'b01: begin
        be_nxt    = address[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{writedata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt;
  logic        err_q;

  assign abort = (state == BUSY) & ~bus.mem_ack
               & (cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (state == BUSY && !bus.mem_ack) begin
      cnt <= cnt + 16'd1;
      if (abort) err_q <= 1'b1;
    end
  end

  assign bus_err = (state == DONE) & err_q;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (bus.mem_ack || abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
      st_q          <= 1'b0;
      rdata_q       <= '0;
    end else begin
      if (start) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= memwrite;
        bus.mem_addr  <= {address[31:2], 2'b00};
        bus.mem_wdata <= wdata_nxt;
        bus.mem_be    <= be_nxt;
        f3_q          <= funct3;
        lo_q          <= address[1:0];
        st_q          <= memwrite;
      end
      if (state == BUSY && bus.mem_ack) begin
        bus.mem_req <= 1'b0;
        rdata_q     <= bus.mem_rdata;
      end else if (abort) begin
        bus.mem_req <= 1'b0;
        rdata_q     <= '0;
      end
    end
  end

  assign byte_l = rdata_q[{lo_q, 3'b000} +: 8];
  assign half_l = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ext = rdata_q;
    case (f3_q)
      3'd0:    ext = {{24{byte_l[7]}}, byte_l};
      3'd1:    ext = {{16{half_l[15]}}, half_l};
      3'd4:    ext = {24'h0, byte_l};
      3'd5:    ext = {16'h0, half_l};
      default: ext = rdata_q;
    endcase
  end

  assign readdata = (state == DONE && !st_q && !bus_err) ? ext : 32'h0;

endmodule
